// File: rtl/series_mux_pkg.sv
// Shared constants and types for the series mux arbiter.
package series_mux_pkg;

  localparam int N_REQ_DEFAULT  = 8;
  localparam int DATA_W_DEFAULT = 8;

  // Output register occupancy: EMPTY means out_valid is low.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage : series_mux_pkg

// File: rtl/rr_priority_pick.sv
// Rotating-priority search: the first set bit of req at or above ptr wins,
// wrapping from N-1 back to 0.
module rr_priority_pick #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any_req
);

  int idx;

  // Walk N positions starting at ptr; the first requester seen takes the grant.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    gnt_onehot = '0;
    gnt_idx    = '0;
    any_req    = 1'b0;
    idx        = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any_req && req[idx]) begin
        any_req         = 1'b1;
        gnt_idx         = IDX_W'(idx);
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

endmodule : rr_priority_pick

// File: rtl/series_mux_arbiter.sv
// N-to-1 round-robin arbiter feeding a single registered output stage.
// A word is accepted and the previous one released in the same cycle, so
// sustained throughput is one word per clock with one cycle of latency.
module series_mux_arbiter
  import series_mux_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int SRC_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic [SRC_W-1:0]        out_src,
  input  logic                    out_ready
);

  state_t            state;
  state_t            state_nxt;
  logic [SRC_W-1:0]  ptr;
  logic [N_REQ-1:0]  gnt_onehot;
  logic [SRC_W-1:0]  gnt_idx;
  logic              any_req;
  logic              load;
  logic              take;
  logic [DATA_W-1:0] win_data;

  rr_priority_pick #(
    .N     (N_REQ),
    .IDX_W (SRC_W)
  ) u_pick (
    .req        (req_valid),
    .ptr        (ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any_req    (any_req)
  );

  // The output register can take a new word when empty or being drained.
  // rst_n gates the grant because state already reads EMPTY during reset.
  always_comb begin
    load      = (state == EMPTY) || out_ready;
    take      = load && any_req && rst_n;
    req_ready = take ? gnt_onehot : '0;
    win_data  = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
    out_valid = (state == FULL);
  end

  // Next state: fill on a handshake, empty when drained with nothing waiting.
  always_comb begin
    state_nxt = state;
    if (load) state_nxt = any_req ? FULL : EMPTY;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Output payload, source index and round-robin pointer move only on a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: these are plain registers, not a memory, so all of them are reset.
    if (!rst_n) begin
      out_data <= '0;
      out_src  <= '0;
      ptr      <= '0;
    end else if (take) begin
      out_data <= win_data;
      out_src  <= gnt_idx;
      ptr      <= (gnt_idx == SRC_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule : series_mux_arbiter

// File: tb/tb_series_mux_arbiter.sv
// Scoreboard bench for series_mux_arbiter with four requesters.
module tb_series_mux_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SW = 2;

  typedef struct {
    logic [SW-1:0] src;
    logic [DW-1:0] data;
  } word_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_src;
  logic            out_ready = 1'b0;

  word_t sb[$];
  int    checks = 0;
  int    errors = 0;

  localparam logic [31:0] D = 32'h43424140;

  series_mux_arbiter #(.N_REQ(N), .DATA_W(DW), .SRC_W(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every word leaving the output register is compared with the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got src %0d data 0x%0h with empty scoreboard", out_src, out_data);
      end else begin
        word_t e;
        e = sb.pop_front();
        check("mon_src", 32'(out_src), 32'(e.src));
        check("mon_data", 32'(out_data), 32'(e.data));
      end
    end
  end

  // Drive one cycle, check the combinational grant, and log the expected word.
  task automatic step(input logic [N-1:0] v, input logic [31:0] d, input logic ordy,
                      input logic [N-1:0] exp_rdy);
    req_valid = v;
    req_data  = d;
    out_ready = ordy;
    #1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    for (int i = 0; i < N; i++)
      if (exp_rdy[i]) sb.push_back('{src: SW'(i), data: d[i*DW +: DW]});
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic v, input logic [SW-1:0] s, input logic [DW-1:0] dat,
                            input logic [SW-1:0] p);
    check("out_valid", 32'(out_valid), 32'(v));
    check("out_src", 32'(out_src), 32'(s));
    check("out_data", 32'(out_data), 32'(dat));
    check("ptr", 32'(dut.ptr), 32'(p));
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    out_ready = 1'b1;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    rst_n = 1'b1;
  endtask

  int mptr;
  bit mfull;
  int skip[N];
  int max_skip;

  initial begin
    // Power-on reset state.
    #1;
    expect_out(1'b0, 2'd0, 8'h00, 2'd0);
    do_reset();

    // All requesters valid: grants rotate 0,1,2,3,0 with out_valid held high.
    step(4'b1111, D, 1'b1, 4'b0001); expect_out(1'b1, 2'd0, 8'h40, 2'd1);
    step(4'b1111, D, 1'b1, 4'b0010); expect_out(1'b1, 2'd1, 8'h41, 2'd2);
    step(4'b1111, D, 1'b1, 4'b0100); expect_out(1'b1, 2'd2, 8'h42, 2'd3);
    step(4'b1111, D, 1'b1, 4'b1000); expect_out(1'b1, 2'd3, 8'h43, 2'd0);
    step(4'b1111, D, 1'b1, 4'b0001); expect_out(1'b1, 2'd0, 8'h40, 2'd1);
    step(4'b0000, D, 1'b1, 4'b0000); expect_out(1'b0, 2'd0, 8'h40, 2'd1);

    // Backpressure holds the word and blocks grants; release grants index 2.
    do_reset();
    step(4'b0101, D, 1'b1, 4'b0001); expect_out(1'b1, 2'd0, 8'h40, 2'd1);
    repeat (3) begin
      step(4'b0101, D, 1'b0, 4'b0000); expect_out(1'b1, 2'd0, 8'h40, 2'd1);
    end
    step(4'b0101, D, 1'b1, 4'b0100); expect_out(1'b1, 2'd2, 8'h42, 2'd3);
    step(4'b0000, D, 1'b1, 4'b0000); expect_out(1'b0, 2'd2, 8'h42, 2'd3);

    // Wrap from ptr 3 past index 3 and 0 to reach index 1.
    step(4'b0010, D, 1'b1, 4'b0010); expect_out(1'b1, 2'd1, 8'h41, 2'd2);
    step(4'b0000, D, 1'b1, 4'b0000); expect_out(1'b0, 2'd1, 8'h41, 2'd2);

    // Single word then drain: payload is held while EMPTY, ptr stays at 3.
    step(4'b0100, 32'h00A50000, 1'b1, 4'b0100); expect_out(1'b1, 2'd2, 8'hA5, 2'd3);
    step(4'b0000, 32'h00A50000, 1'b1, 4'b0000); expect_out(1'b0, 2'd2, 8'hA5, 2'd3);
    step(4'b0000, 32'h00A50000, 1'b1, 4'b0000); expect_out(1'b0, 2'd2, 8'hA5, 2'd3);

    // One requester continuously valid gets every grant back to back.
    repeat (3) begin
      step(4'b1000, D, 1'b1, 4'b1000); expect_out(1'b1, 2'd3, 8'h43, 2'd0);
    end
    step(4'b0000, D, 1'b1, 4'b0000);

    // A requester that drops before being granted leaves ptr alone.
    step(4'b0001, D, 1'b1, 4'b0001); expect_out(1'b1, 2'd0, 8'h40, 2'd1);
    step(4'b0100, D, 1'b0, 4'b0000); expect_out(1'b1, 2'd0, 8'h40, 2'd1);
    step(4'b0000, D, 1'b0, 4'b0000); expect_out(1'b1, 2'd0, 8'h40, 2'd1);
    step(4'b1000, D, 1'b1, 4'b1000); expect_out(1'b1, 2'd3, 8'h43, 2'd0);
    step(4'b0000, D, 1'b1, 4'b0000);

    // Reset mid-cycle while FULL clears everything without a clock edge.
    step(4'b0010, D, 1'b0, 4'b0010); expect_out(1'b1, 2'd1, 8'h41, 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out(1'b0, 2'd0, 8'h00, 2'd0);
    check("rst_mid_req_ready", 32'(req_ready), 32'h0);
    do_reset();
    // First arbitration after release starts from index 0.
    step(4'b1111, D, 1'b1, 4'b0001); expect_out(1'b1, 2'd0, 8'h40, 2'd1);
    step(4'b0000, D, 1'b1, 4'b0000);

    // Random traffic against a reference arbiter, with a fairness bound.
    do_reset();
    mptr = 0;
    mfull = 1'b0;
    max_skip = 0;
    for (int i = 0; i < N; i++) skip[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] v;
      logic [31:0]  d;
      logic         o;
      logic [N-1:0] er;
      int           w;
      v = N'($urandom_range(0, 15));
      d = $urandom;
      o = ($urandom_range(0, 3) != 0);
      w = -1;
      if (!mfull || o)
        for (int k = 0; k < N; k++)
          if (w < 0 && v[(mptr + k) % N]) w = (mptr + k) % N;
      er = (w >= 0) ? N'(1 << w) : '0;
      step(v, d, o, er);
      if (w >= 0) begin
        for (int i = 0; i < N; i++)
          if (i != w && v[i]) begin
            skip[i]++;
            if (skip[i] > max_skip) max_skip = skip[i];
          end
        skip[w] = 0;
        mptr = (w + 1) % N;
        mfull = 1'b1;
      end else if (!mfull || o) begin
        mfull = 1'b0;
      end
      for (int i = 0; i < N; i++) if (!v[i]) skip[i] = 0;
    end
    step(4'b0000, 32'h0, 1'b1, 4'b0000);
    check("fair_skip_bound", 32'(max_skip <= N - 1), 32'h1);
    check("ptr_model", 32'(dut.ptr), 32'(mptr));
    check("sb_empty", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_series_mux_arbiter
